// File: rtl/rom_arbiter_if.sv
// Requester/ROM bus for rom_arbiter: fetch port, data port and the ROM read port.
// The slave modport is the arbiter; the master modport is the requesters plus the ROM.
interface rom_arbiter_if #(
    parameter int RAM_WORD_WIDTH = 24,
    parameter int RAM_ADDR_BITS  = 8
);
    logic                      f_req;
    logic [RAM_ADDR_BITS-1:0]  f_addr;
    logic                      f_ack;
    logic [RAM_WORD_WIDTH-1:0] f_data;
    logic                      d_req;
    logic [RAM_ADDR_BITS-1:0]  d_addr;
    logic                      d_ack;
    logic [RAM_WORD_WIDTH-1:0] d_data;
    logic [RAM_ADDR_BITS-1:0]  rom_addr;
    logic [RAM_WORD_WIDTH-1:0] rom_data;
    logic                      busy;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_data,
        output f_ack, f_data, d_ack, d_data, rom_addr, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, rom_data,
        input  f_ack, f_data, d_ack, d_data, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Shares the single-read-port program ROM between the fetch port and the data port.
// Each access takes two cycles: grant (drive rom_addr), then capture and ack.
//
//   state | meaning
//   IDLE  | no access in flight; arbitrate eligible requests on this edge
//   WAIT  | rom_addr driven, ROM answers on the negedge; capture and ack owner
module rom_arbiter #(
    parameter int RAM_WORD_WIDTH = 24,
    parameter int RAM_ADDR_BITS  = 8,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    rom_arbiter_if.slave  bus
);
    typedef enum logic { IDLE, WAIT } state_t;
    typedef enum logic { FETCH, DATA } port_t;

    state_t                    state;
    port_t                     owner;
    port_t                     last_grant;
    logic                      f_ack_q;
    logic                      d_ack_q;
    logic                      busy_q;
    logic [RAM_WORD_WIDTH-1:0] f_data_q;
    logic [RAM_WORD_WIDTH-1:0] d_data_q;
    logic [RAM_ADDR_BITS-1:0]  rom_addr_q;

    logic elig_f;
    logic elig_d;
    logic grant_fetch;

    // A port whose ack is high this cycle still shows its old req; skip it.
    always_comb begin
        elig_f      = bus.f_req & ~f_ack_q;
        elig_d      = bus.d_req & ~d_ack_q;
        grant_fetch = 1'b0;
        if (elig_f && elig_d)
            grant_fetch = FIXED_PRIO ? 1'b1 : (last_grant == DATA);
        else
            grant_fetch = elig_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= FETCH;
            last_grant <= DATA;
            rom_addr_q <= '0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            f_data_q   <= '0;
            d_data_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig_f || elig_d) begin
                        rom_addr_q <= grant_fetch ? bus.f_addr : bus.d_addr;
                        owner      <= grant_fetch ? FETCH : DATA;
                        last_grant <= grant_fetch ? FETCH : DATA;
                        busy_q     <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner == FETCH) begin
                        f_data_q <= bus.rom_data;
                        f_ack_q  <= 1'b1;
                    end else begin
                        d_data_q <= bus.rom_data;
                        d_ack_q  <= 1'b1;
                    end
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.f_ack    = f_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.f_data   = f_data_q;
    assign bus.d_data   = d_data_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a round-robin instance and a fixed-priority
// instance, each with its own negedge-registered ROM model.
module tb_rom_arbiter;
    localparam int W = 24;
    localparam int A = 8;
    localparam logic [W-1:0] NOP_WORD = 24'hE00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] mem [0:255];

    rom_arbiter_if #(.RAM_WORD_WIDTH(W), .RAM_ADDR_BITS(A)) bus_rr ();
    rom_arbiter_if #(.RAM_WORD_WIDTH(W), .RAM_ADDR_BITS(A)) bus_fp ();

    rom_arbiter #(.RAM_WORD_WIDTH(W), .RAM_ADDR_BITS(A), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .bus(bus_rr.slave));
    rom_arbiter #(.RAM_WORD_WIDTH(W), .RAM_ADDR_BITS(A), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp.slave));

    always @(negedge clk) begin
        bus_rr.rom_data <= mem[bus_rr.rom_addr];
        bus_fp.rom_data <= mem[bus_fp.rom_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_rr.f_req = 1'b0; bus_rr.d_req = 1'b0; bus_rr.f_addr = '0; bus_rr.d_addr = '0;
        bus_fp.f_req = 1'b0; bus_fp.d_req = 1'b0; bus_fp.f_addr = '0; bus_fp.d_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_rr.f_req = 1'b1; bus_rr.d_req = 1'b1; bus_rr.f_addr = 8'd5; bus_rr.d_addr = 8'd20;
        bus_fp.f_req = 1'b1; bus_fp.d_req = 1'b1; bus_fp.f_addr = 8'd5; bus_fp.d_addr = 8'd20;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (bus_rr.f_ack !== 1'b0) begin errors++; $display("FAIL reset_f_ack: got %b want 0", bus_rr.f_ack); end
            checks++; if (bus_rr.d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack: got %b want 0", bus_rr.d_ack); end
            checks++; if (bus_rr.rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", bus_rr.rom_addr); end
            checks++; if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_rr.busy); end
            checks++; if (bus_fp.f_ack !== 1'b0) begin errors++; $display("FAIL reset_fp_f_ack: got %b want 0", bus_fp.f_ack); end
        end
        checks++; if (bus_rr.f_data !== 24'h0) begin errors++; $display("FAIL reset_f_data: got %h want 000000", bus_rr.f_data); end
        checks++; if (bus_rr.d_data !== 24'h0) begin errors++; $display("FAIL reset_d_data: got %h want 000000", bus_rr.d_data); end
        idle_all();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        bus_rr.f_req = 1'b1; bus_rr.f_addr = 8'd5;
        step();
        checks++; if (bus_rr.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus_rr.busy); end
        checks++; if (bus_rr.rom_addr !== 8'd5) begin errors++; $display("FAIL single_rom_addr: got %0d want 5", bus_rr.rom_addr); end
        checks++; if (bus_rr.f_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack: got %b want 0", bus_rr.f_ack); end
        step();
        checks++; if (bus_rr.f_ack !== 1'b1) begin errors++; $display("FAIL single_f_ack: got %b want 1", bus_rr.f_ack); end
        checks++; if (bus_rr.f_data !== 24'h0A0003) begin errors++; $display("FAIL single_f_data: got %h want 0a0003", bus_rr.f_data); end
        checks++; if (bus_rr.d_ack !== 1'b0) begin errors++; $display("FAIL single_d_ack: got %b want 0", bus_rr.d_ack); end
        checks++; if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL single_busy_clr: got %b want 0", bus_rr.busy); end
        bus_rr.f_req = 1'b0;
        step();
        checks++; if (bus_rr.f_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pulse: got %b want 0", bus_rr.f_ack); end
        checks++; if (bus_rr.f_data !== 24'h0A0003) begin errors++; $display("FAIL single_data_hold: got %h want 0a0003", bus_rr.f_data); end
    endtask

    task automatic test_contention_rr();
        logic exp_f;
        logic exp_d;
        do_reset();
        bus_rr.f_req = 1'b1; bus_rr.d_req = 1'b1; bus_rr.f_addr = 8'd1; bus_rr.d_addr = 8'd20;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_f = (k % 4 == 2);
            exp_d = (k % 4 == 0);
            checks++; if (bus_rr.f_ack !== exp_f) begin errors++; $display("FAIL rr_f_ack cycle %0d: got %b want %b", k, bus_rr.f_ack, exp_f); end
            checks++; if (bus_rr.d_ack !== exp_d) begin errors++; $display("FAIL rr_d_ack cycle %0d: got %b want %b", k, bus_rr.d_ack, exp_d); end
            if (exp_f) begin
                checks++; if (bus_rr.f_data !== mem[1]) begin errors++; $display("FAIL rr_f_data cycle %0d: got %h want %h", k, bus_rr.f_data, mem[1]); end
            end
            if (exp_d) begin
                checks++; if (bus_rr.d_data !== mem[20]) begin errors++; $display("FAIL rr_d_data cycle %0d: got %h want %h", k, bus_rr.d_data, mem[20]); end
            end
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_fixed_prio();
        do_reset();
        // Serve one fetch on both instances so last_grant is FETCH on each.
        bus_rr.f_req = 1'b1; bus_rr.f_addr = 8'd1;
        bus_fp.f_req = 1'b1; bus_fp.f_addr = 8'd1;
        step();
        step();
        bus_rr.f_req = 1'b0; bus_fp.f_req = 1'b0;
        step();
        bus_rr.f_req = 1'b1; bus_rr.d_req = 1'b1; bus_rr.f_addr = 8'd1; bus_rr.d_addr = 8'd20;
        bus_fp.f_req = 1'b1; bus_fp.d_req = 1'b1; bus_fp.f_addr = 8'd1; bus_fp.d_addr = 8'd20;
        step();
        checks++; if (bus_rr.rom_addr !== 8'd20) begin errors++; $display("FAIL rr_turn_grant: got %0d want 20", bus_rr.rom_addr); end
        checks++; if (bus_fp.rom_addr !== 8'd1) begin errors++; $display("FAIL fp_prio_grant: got %0d want 1", bus_fp.rom_addr); end
        step();
        checks++; if (bus_rr.d_ack !== 1'b1) begin errors++; $display("FAIL rr_turn_d_ack: got %b want 1", bus_rr.d_ack); end
        checks++; if (bus_fp.f_ack !== 1'b1) begin errors++; $display("FAIL fp_prio_f_ack: got %b want 1", bus_fp.f_ack); end
        checks++; if (bus_fp.d_ack !== 1'b0) begin errors++; $display("FAIL fp_prio_d_ack: got %b want 0", bus_fp.d_ack); end
        bus_rr.f_req = 1'b0; bus_rr.d_req = 1'b0;
        bus_fp.f_req = 1'b0;
        step();
        checks++; if (bus_fp.rom_addr !== 8'd20) begin errors++; $display("FAIL fp_d_grant: got %0d want 20", bus_fp.rom_addr); end
        step();
        checks++; if (bus_fp.d_ack !== 1'b1) begin errors++; $display("FAIL fp_d_ack: got %b want 1", bus_fp.d_ack); end
        checks++; if (bus_fp.d_data !== mem[20]) begin errors++; $display("FAIL fp_d_data: got %h want %h", bus_fp.d_data, mem[20]); end
        idle_all();
        step();
    endtask

    task automatic test_no_double();
        do_reset();
        bus_rr.f_req = 1'b1; bus_rr.f_addr = 8'd7;
        step();
        step();
        checks++; if (bus_rr.f_ack !== 1'b1) begin errors++; $display("FAIL nodbl_ack: got %b want 1", bus_rr.f_ack); end
        checks++; if (bus_rr.f_data !== mem[7]) begin errors++; $display("FAIL nodbl_data: got %h want %h", bus_rr.f_data, mem[7]); end
        step();
        checks++; if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL nodbl_regrant: got busy=%b want 0", bus_rr.busy); end
        checks++; if (bus_rr.f_ack !== 1'b0) begin errors++; $display("FAIL nodbl_ack_clr: got %b want 0", bus_rr.f_ack); end
        bus_rr.f_req = 1'b0;
        step();
        checks++; if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL nodbl_idle: got busy=%b want 0", bus_rr.busy); end
        step();
        checks++; if (bus_rr.f_ack !== 1'b0) begin errors++; $display("FAIL nodbl_extra_ack: got %b want 0", bus_rr.f_ack); end
    endtask

    task automatic test_back_to_back();
        bus_rr.f_req = 1'b1; bus_rr.f_addr = 8'd255;
        step();
        checks++; if (bus_rr.rom_addr !== 8'd255) begin errors++; $display("FAIL b2b_addr_top: got %0d want 255", bus_rr.rom_addr); end
        step();
        checks++; if (bus_rr.f_data !== mem[255]) begin errors++; $display("FAIL b2b_data_top: got %h want %h", bus_rr.f_data, mem[255]); end
        bus_rr.f_addr = 8'd254;
        step();
        checks++; if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b want 0", bus_rr.busy); end
        step();
        checks++; if (bus_rr.rom_addr !== 8'd254) begin errors++; $display("FAIL b2b_addr_next: got %0d want 254", bus_rr.rom_addr); end
        step();
        checks++; if (bus_rr.f_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_next: got %b want 1", bus_rr.f_ack); end
        checks++; if (bus_rr.f_data !== mem[254]) begin errors++; $display("FAIL b2b_data_next: got %h want %h", bus_rr.f_data, mem[254]); end
        idle_all();
        step();
    endtask

    task automatic test_rst_in_wait();
        do_reset();
        bus_rr.d_req = 1'b1; bus_rr.d_addr = 8'd9;
        step();
        checks++; if (bus_rr.rom_addr !== 8'd9) begin errors++; $display("FAIL rstw_grant: got %0d want 9", bus_rr.rom_addr); end
        rst = 1'b1;
        step();
        checks++; if (bus_rr.d_ack !== 1'b0) begin errors++; $display("FAIL rstw_no_ack: got %b want 0", bus_rr.d_ack); end
        checks++; if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b want 0", bus_rr.busy); end
        checks++; if (bus_rr.rom_addr !== 8'd0) begin errors++; $display("FAIL rstw_rom_addr: got %0d want 0", bus_rr.rom_addr); end
        rst = 1'b0;
        bus_rr.d_addr = 8'd0;
        step();
        checks++; if (bus_rr.busy !== 1'b1) begin errors++; $display("FAIL rstw_retry_busy: got %b want 1", bus_rr.busy); end
        step();
        checks++; if (bus_rr.d_ack !== 1'b1) begin errors++; $display("FAIL rstw_retry_ack: got %b want 1", bus_rr.d_ack); end
        checks++; if (bus_rr.d_data !== NOP_WORD) begin errors++; $display("FAIL rstw_retry_data: got %h want %h", bus_rr.d_data, NOP_WORD); end
        idle_all();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'hA5, ~8'(i)};
        mem[0] = NOP_WORD;
        mem[5] = 24'h0A0003;
        idle_all();
        test_reset();
        test_single_fetch();
        test_contention_rr();
        test_fixed_prio();
        test_no_double();
        test_back_to_back();
        test_rst_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
